// File: rtl/cpu_pkg.sv
// Shared types and constants for the ALU-sharing arbiter and its bench.
package cpu_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int OP_W_DEF   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;

endpackage

// File: rtl/alu_share_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to prio_i.
module rr_pick2 (
    input  logic [1:0] valid_i,
    input  logic       prio_i,
    output logic [1:0] grant_o,
    output logic       winner_o
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        winner_o = 1'b0;
        grant_o  = 2'b00;
        case (valid_i)
            2'b01:   winner_o = 1'b0;
            2'b10:   winner_o = 1'b1;
            2'b11:   winner_o = prio_i;
            default: winner_o = 1'b0;
        endcase
        if (valid_i != 2'b00) begin
            grant_o = winner_o ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the execute stage (port 0) and the
// debug/host port (port 1): accept, issue from registered operands, respond.
module alu_share_arbiter
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              busy
);

    arb_state_t        state_q, state_d;
    logic              prio_q, prio_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [OP_W-1:0]   op_q, op_d;

    logic [1:0] grant;
    logic       winner;
    logic       idle, accept, rsp_done;

    rr_pick2 u_pick (
        .valid_i  ({req1_valid, req0_valid}),
        .prio_i   (prio_q),
        .grant_o  (grant),
        .winner_o (winner)
    );

    // Ready is masked while reset is held so nothing looks accepted during reset.
    assign idle       = reset && (state_q == IDLE);
    assign req0_ready = idle && grant[0];
    assign req1_ready = idle && grant[1];
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign rsp0_valid = (state_q == RESP) && !owner_q;
    assign rsp1_valid = (state_q == RESP) &&  owner_q;
    assign rsp0_data  = result_q;
    assign rsp1_data  = result_q;
    assign rsp_done   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

    assign alu_a = a_q;
    assign alu_b = b_q;
    assign alu_op = op_q;
    assign busy  = (state_q != IDLE);

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        owner_d  = owner_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ISSUE;
                    owner_d = winner;
                    a_d     = winner ? req1_a  : req0_a;
                    b_d     = winner ? req1_b  : req0_b;
                    op_d    = winner ? req1_op : req0_op;
                end
            end
            ISSUE: begin
                result_d = alu_result;
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_done) begin
                    state_d = IDLE;
                    prio_d  = !owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: operand and result registers are reset too, so the ALU and
        // response buses read 0 straight after reset rather than stale data.
        if (!reset) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            owner_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state_q  <= state_d;
            prio_q   <= prio_d;
            owner_q  <= owner_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

endmodule
